// File: rtl/i2c_byte_ctl_if.sv
// Byte-level request, status and bit-controller signals of the I2C byte sequencer.
interface i2c_byte_ctl_if;
  localparam int unsigned DW = 8;

  // Host request side
  logic          start;
  logic          restart;
  logic          write;
  logic          read;
  logic          stop;
  logic          ack_in;
  logic [DW-1:0] din;

  // Host status side
  logic          cmd_ack;
  logic          ack_out;
  logic [DW-1:0] dout;
  logic          i2c_busy;
  logic          i2c_al;

  // Bit controller side
  logic [2:0]    bit_cmd;
  logic          bit_din;
  logic          bit_ack;
  logic          bit_arblost;
  logic          bit_dout;

  // Sequencer view
  modport master (
    input  start, restart, write, read, stop, ack_in, din,
    input  bit_ack, bit_arblost, bit_dout,
    output cmd_ack, ack_out, dout, i2c_busy, i2c_al,
    output bit_cmd, bit_din
  );

  // Host plus bit-controller view
  modport slave (
    output start, restart, write, read, stop, ack_in, din,
    output bit_ack, bit_arblost, bit_dout,
    input  cmd_ack, ack_out, dout, i2c_busy, i2c_al,
    input  bit_cmd, bit_din
  );
endinterface

// File: rtl/i2c_byte_ctl.sv
// Byte-level I2C master sequencer: turns one byte request into bit-controller commands.
module i2c_byte_ctl (
  input  logic           sysclk,
  input  logic           nReset,
  input  logic           enable,
  i2c_byte_ctl_if.master bus
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;

  localparam logic [2:0] CMD_IDLE    = 3'd0;
  localparam logic [2:0] CMD_START   = 3'd1;
  localparam logic [2:0] CMD_STOP    = 3'd2;
  localparam logic [2:0] CMD_WRITE   = 3'd3;
  localparam logic [2:0] CMD_READ    = 3'd4;
  localparam logic [2:0] CMD_RESTART = 3'd5;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_ACK   = 3'd4;
  localparam logic [2:0] ST_STOP  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [2:0]    bit_cmd_q, bit_cmd_d;
  logic          bit_din_q, bit_din_d;
  logic          cmd_ack_q, cmd_ack_d;
  logic          ack_out_q, ack_out_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          busy_q, busy_d;
  logic          al_q, al_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] shift_q, shift_d;

  // Latched request bits
  logic          start_q, start_d;
  logic          restart_q, restart_d;
  logic          wr_q, wr_d;
  logic          rd_q, rd_d;
  logic          stop_q, stop_d;
  logic          ack_in_q, ack_in_d;

  // Phase transition request from the current state
  logic          adv;
  logic [2:0]    adv_st;
  logic          last_bit;

  // First phase after START (or immediately, without START); write wins over read
  function automatic logic [2:0] data_phase(input logic wr, input logic rd, input logic sp);
    if (wr)      data_phase = ST_WRITE;
    else if (rd) data_phase = ST_READ;
    else if (sp) data_phase = ST_STOP;
    else         data_phase = ST_IDLE;
  endfunction

  assign last_bit = (cnt_q == CW'(DW - 1));

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    bit_cmd_d = bit_cmd_q;
    bit_din_d = bit_din_q;
    cmd_ack_d = 1'b0;
    ack_out_d = ack_out_q;
    dout_d    = dout_q;
    busy_d    = busy_q;
    al_d      = al_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    start_d   = start_q;
    restart_d = restart_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    stop_d    = stop_q;
    ack_in_d  = ack_in_q;
    adv       = 1'b0;
    adv_st    = ST_IDLE;

    case (state_q)
      ST_IDLE: begin
        // No new request is taken in the completion-pulse cycle
        if (!cmd_ack_q && (bus.start || bus.write || bus.read || bus.stop)) begin
          start_d   = bus.start;
          restart_d = bus.restart;
          wr_d      = bus.write;
          rd_d      = bus.read;
          stop_d    = bus.stop;
          ack_in_d  = bus.ack_in;
          shift_d   = bus.din;
          cnt_d     = '0;
          al_d      = 1'b0;
          adv       = 1'b1;
          adv_st    = bus.start ? ST_START : data_phase(bus.write, bus.read, bus.stop);
        end
      end
      ST_START: begin
        if (bus.bit_ack) begin
          busy_d = 1'b1;
          adv    = 1'b1;
          adv_st = data_phase(wr_q, rd_q, stop_q);
        end
      end
      ST_WRITE: begin
        if (bus.bit_ack) begin
          shift_d = {shift_q[DW-2:0], 1'b0};
          cnt_d   = cnt_q + CW'(1);
          adv     = 1'b1;
          adv_st  = last_bit ? ST_ACK : ST_WRITE;
        end
      end
      ST_READ: begin
        if (bus.bit_ack) begin
          shift_d = {shift_q[DW-2:0], bus.bit_dout};
          cnt_d   = cnt_q + CW'(1);
          adv     = 1'b1;
          adv_st  = last_bit ? ST_ACK : ST_READ;
        end
      end
      ST_ACK: begin
        if (bus.bit_ack) begin
          if (wr_q) ack_out_d = bus.bit_dout;
          else      dout_d    = shift_q;
          adv    = 1'b1;
          adv_st = stop_q ? ST_STOP : ST_IDLE;
        end
      end
      ST_STOP: begin
        if (bus.bit_ack) begin
          busy_d = 1'b0;
          adv    = 1'b1;
          adv_st = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cmd_d = CMD_IDLE;
        bit_din_d = 1'b1;
      end
    endcase

    // Entering a phase loads the command for it; returning to IDLE completes the request
    if (adv) begin
      state_d = adv_st;
      case (adv_st)
        ST_START: begin
          bit_cmd_d = restart_d ? CMD_RESTART : CMD_START;
          bit_din_d = 1'b1;
        end
        ST_WRITE: begin
          bit_cmd_d = CMD_WRITE;
          bit_din_d = shift_d[DW-1];
        end
        ST_READ: begin
          bit_cmd_d = CMD_READ;
          bit_din_d = 1'b1;
        end
        ST_ACK: begin
          // After a write we listen for the slave ACK; after a read we drive ours
          bit_cmd_d = wr_d ? CMD_READ : CMD_WRITE;
          bit_din_d = wr_d ? 1'b1 : ack_in_d;
        end
        ST_STOP: begin
          bit_cmd_d = CMD_STOP;
          bit_din_d = 1'b1;
        end
        default: begin
          bit_cmd_d = CMD_IDLE;
          bit_din_d = 1'b1;
          cmd_ack_d = 1'b1;
        end
      endcase
    end

    // Lost arbitration aborts the request and overrides a coincident bit_ack
    if (state_q != ST_IDLE && bus.bit_arblost) begin
      state_d   = ST_IDLE;
      bit_cmd_d = CMD_IDLE;
      bit_din_d = 1'b1;
      busy_d    = 1'b0;
      al_d      = 1'b1;
      cmd_ack_d = 1'b1;
      ack_out_d = ack_out_q;
      dout_d    = dout_q;
      shift_d   = shift_q;
      cnt_d     = '0;
      start_d   = 1'b0;
      restart_d = 1'b0;
      wr_d      = 1'b0;
      rd_d      = 1'b0;
      stop_d    = 1'b0;
      ack_in_d  = 1'b0;
    end
  end

  // State and output registers; enable low acts as reset
  always_ff @(posedge sysclk) begin
    if (!nReset || !enable) begin
      state_q   <= ST_IDLE;
      bit_cmd_q <= CMD_IDLE;
      bit_din_q <= 1'b1;
      cmd_ack_q <= 1'b0;
      ack_out_q <= 1'b0;
      dout_q    <= '0;
      busy_q    <= 1'b0;
      al_q      <= 1'b0;
      cnt_q     <= '0;
      shift_q   <= '0;
      start_q   <= 1'b0;
      restart_q <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      stop_q    <= 1'b0;
      ack_in_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cmd_q <= bit_cmd_d;
      bit_din_q <= bit_din_d;
      cmd_ack_q <= cmd_ack_d;
      ack_out_q <= ack_out_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      al_q      <= al_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      start_q   <= start_d;
      restart_q <= restart_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      stop_q    <= stop_d;
      ack_in_q  <= ack_in_d;
    end
  end

  assign bus.bit_cmd  = bit_cmd_q;
  assign bus.bit_din  = bit_din_q;
  assign bus.cmd_ack  = cmd_ack_q;
  assign bus.ack_out  = ack_out_q;
  assign bus.dout     = dout_q;
  assign bus.i2c_busy = busy_q;
  assign bus.i2c_al   = al_q;

  // start_q is kept for visibility of the latched request only
  logic unused_start;
  assign unused_start = start_q;

endmodule

// File: tb/tb_i2c_byte_ctl.sv
// Scoreboard bench for i2c_byte_ctl with a behavioural bit-controller responder.
module tb_i2c_byte_ctl;

  localparam logic [2:0] C_IDLE = 3'd0, C_START = 3'd1, C_STOP = 3'd2,
                         C_WRITE = 3'd3, C_READ = 3'd4, C_RESTART = 3'd5;

  logic sysclk = 1'b0;
  logic nReset = 1'b0;
  logic enable = 1'b1;

  i2c_byte_ctl_if bus ();

  i2c_byte_ctl dut (
    .sysclk (sysclk),
    .nReset (nReset),
    .enable (enable),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  typedef struct packed {
    logic [2:0] cmd;
    logic       din;
    logic       care;
  } cmd_t;

  typedef struct packed {
    logic [7:0] dout;
    logic       ack;
    logic       busy;
    logic       al;
  } res_t;

  cmd_t exp_cmd[$];
  res_t exp_res[$];
  logic rd_bits[$];

  int total = 0;
  int bad = 0;
  int ack_dly = 20;
  int arb_at = 0;
  int cmd_idx = 0;

  logic       m_busy = 1'b0;
  logic       m_ack = 1'b0;
  logic [7:0] m_dout = 8'h00;

  int       bm_cnt = 0;
  int       bm_dly = 1;
  logic [3:0] bm_cur = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare each acknowledged bit command against the expected sequence
  task automatic log_cmd();
    cmd_t e;
    if (exp_cmd.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_cmd: got cmd %0d din %0b, expected none at %0t",
               bus.bit_cmd, bus.bit_din, $time);
    end else begin
      e = exp_cmd.pop_front();
      chk("bit_cmd", 32'(bus.bit_cmd), 32'(e.cmd));
      if (e.care) chk("bit_din", 32'(bus.bit_din), 32'(e.din));
    end
  endtask

  // Bit-controller responder: acks each command after a delay, supplies read bits
  initial begin
    bus.bit_ack = 1'b0;
    bus.bit_arblost = 1'b0;
    bus.bit_dout = 1'b1;
    forever begin
      @(negedge sysclk);
      if (!nReset || !enable) begin
        bus.bit_ack = 1'b0;
        bus.bit_arblost = 1'b0;
        bm_cnt = 0;
      end else if (bus.bit_ack) begin
        bus.bit_ack = 1'b0;
        bus.bit_arblost = 1'b0;
        bm_cnt = 0;
      end else if (bus.bit_cmd != C_IDLE) begin
        if (bm_cnt == 0) begin
          bm_cur = {bus.bit_cmd, bus.bit_din};
          bm_dly = (ack_dly > 0) ? ack_dly : int'($urandom_range(1, 25));
        end
        bm_cnt++;
        if (bm_cnt >= bm_dly) begin
          chk("cmd_held", 32'({bus.bit_cmd, bus.bit_din}), 32'(bm_cur));
          log_cmd();
          bus.bit_ack = 1'b1;
          cmd_idx++;
          if (cmd_idx == arb_at) bus.bit_arblost = 1'b1;
          if (bus.bit_cmd == C_READ)
            bus.bit_dout = (rd_bits.size() > 0) ? rd_bits.pop_front() : 1'b1;
        end
      end else begin
        bm_cnt = 0;
      end
    end
  end

  // Result monitor: every cmd_ack pops one expected result
  initial begin
    res_t r;
    forever begin
      @(negedge sysclk);
      if (bus.cmd_ack) begin
        if (exp_res.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_cmd_ack: got cmd_ack=1 expected 0 at %0t", $time);
        end else begin
          r = exp_res.pop_front();
          chk("dout", 32'(bus.dout), 32'(r.dout));
          chk("ack_out", 32'(bus.ack_out), 32'(r.ack));
          chk("i2c_busy", 32'(bus.i2c_busy), 32'(r.busy));
          chk("i2c_al", 32'(bus.i2c_al), 32'(r.al));
          chk("cmds_left", 32'(exp_cmd.size()), 32'd0);
          chk("idle_on_ack", 32'(bus.bit_cmd), 32'(C_IDLE));
        end
      end
    end
  end

  // Reference model: expected bit command list for one request
  task automatic build_cmds(input logic st, input logic rs, input logic wr, input logic rd,
                            input logic sp, input logic [7:0] d, input logic ain,
                            input logic sack, input logic [7:0] rbyte, output cmd_t q[$]);
    cmd_t c;
    q.delete();
    if (st) begin
      c.cmd = rs ? C_RESTART : C_START; c.din = 1'b1; c.care = 1'b0; q.push_back(c);
    end
    if (wr) begin
      for (int i = 7; i >= 0; i--) begin
        c.cmd = C_WRITE; c.din = d[i]; c.care = 1'b1; q.push_back(c);
      end
      c.cmd = C_READ; c.din = 1'b1; c.care = 1'b0; q.push_back(c);
      rd_bits.push_back(sack);
    end else if (rd) begin
      for (int i = 7; i >= 0; i--) begin
        c.cmd = C_READ; c.din = 1'b1; c.care = 1'b0; q.push_back(c);
        rd_bits.push_back(rbyte[i]);
      end
      c.cmd = C_WRITE; c.din = ain; c.care = 1'b1; q.push_back(c);
    end
    if (sp) begin
      c.cmd = C_STOP; c.din = 1'b1; c.care = 1'b1; q.push_back(c);
    end
  endtask

  // Issue one request, held high until the completion pulse, then dropped
  task automatic run_txn(input logic st, input logic rs, input logic wr, input logic rd,
                         input logic sp, input logic [7:0] d, input logic ain,
                         input logic sack, input logic [7:0] rbyte, input int arb);
    cmd_t q[$];
    res_t r;
    int a;
    int t;
    build_cmds(st, rs, wr, rd, sp, d, ain, sack, rbyte, q);
    a = arb;
    if (a < 0) a = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, q.size())) : 0;
    if (a > q.size()) a = 0;
    if (a > 0) begin
      while (q.size() > a) void'(q.pop_back());
      m_busy = 1'b0;
      r.al = 1'b1;
    end else begin
      if (wr) m_ack = sack;
      else if (rd) m_dout = rbyte;
      if (st) m_busy = 1'b1;
      if (sp) m_busy = 1'b0;
      r.al = 1'b0;
    end
    r.dout = m_dout; r.ack = m_ack; r.busy = m_busy;
    foreach (q[i]) exp_cmd.push_back(q[i]);
    exp_res.push_back(r);
    cmd_idx = 0;
    arb_at = a;

    @(negedge sysclk);
    bus.start = st; bus.restart = rs; bus.write = wr; bus.read = rd; bus.stop = sp;
    bus.din = d; bus.ack_in = ain;
    @(negedge sysclk);
    chk("first_cmd", 32'(bus.bit_cmd), 32'(q[0].cmd));
    t = 0;
    while (!bus.cmd_ack && t < 4000) begin
      @(negedge sysclk);
      t++;
    end
    if (t >= 4000) begin
      chk("cmd_ack_timeout", 32'(bus.cmd_ack), 32'd1);
      exp_cmd.delete();
      exp_res.delete();
    end
    @(negedge sysclk);
    chk("single_cmd_ack", 32'(bus.cmd_ack), 32'd0);
    bus.start = 1'b0; bus.restart = 1'b0; bus.write = 1'b0; bus.read = 1'b0; bus.stop = 1'b0;
    @(negedge sysclk);
    chk("idle_after_drop", 32'(bus.bit_cmd), 32'(C_IDLE));
    rd_bits.delete();
    arb_at = 0;
  endtask

  // Watchdog
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic st, rs, wr, rd, sp;
    int t;
    bus.start = 1'b0; bus.restart = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
    bus.stop = 1'b0; bus.ack_in = 1'b0; bus.din = 8'h00;

    repeat (3) @(negedge sysclk);
    chk("rst_bit_cmd", 32'(bus.bit_cmd), 32'(C_IDLE));
    chk("rst_bit_din", 32'(bus.bit_din), 32'd1);
    chk("rst_cmd_ack", 32'(bus.cmd_ack), 32'd0);
    chk("rst_ack_out", 32'(bus.ack_out), 32'd0);
    chk("rst_dout", 32'(bus.dout), 32'd0);
    chk("rst_busy", 32'(bus.i2c_busy), 32'd0);
    chk("rst_al", 32'(bus.i2c_al), 32'd0);
    nReset = 1'b1;
    repeat (2) @(negedge sysclk);

    // Directed cases with a fixed 20-cycle bit controller
    ack_dly = 20;
    run_txn(1, 0, 1, 0, 0, 8'hA5, 0, 0, 8'h00, 0);
    run_txn(1, 1, 1, 0, 0, 8'h5A, 0, 1, 8'h00, 0);
    run_txn(0, 0, 0, 1, 1, 8'h00, 1, 0, 8'h3C, 0);
    run_txn(1, 0, 1, 0, 0, 8'hC3, 0, 0, 8'h00, 5);
    run_txn(1, 0, 1, 1, 0, 8'h81, 0, 1, 8'hFF, 0);
    run_txn(0, 0, 0, 0, 1, 8'h00, 0, 0, 8'h00, 0);

    // Randomized requests and bit-controller timing
    ack_dly = 0;
    for (int n = 0; n < 40; n++) begin
      st = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      sp = 1'($urandom_range(0, 1));
      if (!(st || wr || rd || sp)) wr = 1'b1;
      run_txn(st, rs, wr, rd, sp, 8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), -1);
    end

    // Enable low clears status
    ack_dly = 20;
    run_txn(1, 0, 1, 0, 0, 8'h3E, 0, 0, 8'h00, 0);
    @(negedge sysclk);
    enable = 1'b0;
    @(negedge sysclk);
    chk("en_busy", 32'(bus.i2c_busy), 32'd0);
    chk("en_dout", 32'(bus.dout), 32'd0);
    enable = 1'b1;
    m_busy = 1'b0; m_ack = 1'b0; m_dout = 8'h00;
    @(negedge sysclk);

    // Reset during the fifth read bit
    run_txn(1, 0, 1, 0, 0, 8'h77, 0, 0, 8'h00, 0);
    begin
      cmd_t q[$];
      build_cmds(0, 0, 0, 1, 0, 8'h00, 0, 0, 8'h96, q);
      foreach (q[i]) exp_cmd.push_back(q[i]);
    end
    cmd_idx = 0;
    @(negedge sysclk);
    bus.read = 1'b1; bus.ack_in = 1'b0;
    t = 0;
    while (cmd_idx < 4 && t < 500) begin
      @(negedge sysclk);
      t++;
    end
    chk("reach_5th_bit", 32'(cmd_idx), 32'd4);
    repeat (5) @(negedge sysclk);
    chk("mid_read_cmd", 32'(bus.bit_cmd), 32'(C_READ));
    nReset = 1'b0;
    bus.read = 1'b0;
    exp_cmd.delete();
    rd_bits.delete();
    @(negedge sysclk);
    chk("rr_bit_cmd", 32'(bus.bit_cmd), 32'(C_IDLE));
    chk("rr_bit_din", 32'(bus.bit_din), 32'd1);
    chk("rr_cmd_ack", 32'(bus.cmd_ack), 32'd0);
    chk("rr_busy", 32'(bus.i2c_busy), 32'd0);
    chk("rr_al", 32'(bus.i2c_al), 32'd0);
    chk("rr_dout", 32'(bus.dout), 32'd0);
    chk("rr_ack_out", 32'(bus.ack_out), 32'd0);
    repeat (2) @(negedge sysclk);
    nReset = 1'b1;
    repeat (40) @(negedge sysclk);
    chk("post_rst_idle", 32'(bus.bit_cmd), 32'(C_IDLE));
    chk("post_rst_res_left", 32'(exp_res.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_byte_ctl.md
# i2c_byte_ctl

Byte-level I2C master sequencer sitting directly upstream of the I2C bit controller. Takes one byte-level request (optional START/RESTART, WRITE or READ of 8 bits, ACK phase, optional STOP) from the register/host layer. Issues the corresponding sequence of single-bit commands to the bit controller, then returns the received byte, the received ACK, bus-busy and arbitration-lost status.

## Interface
Parameters:
- none; command encodings are the shared i2c-def.v constants: CMD_IDLE=0, CMD_START=1, CMD_STOP=2, CMD_WRITE=3, CMD_READ=4, CMD_RESTART=5.

Ports:
- sysclk  in  1  system clock; all logic on rising edge
- nReset  in  1  reset, synchronous, active-low
- enable  in  1  core enable; low behaves as reset
- start  in  1  request: generate START before the data phase
- restart  in  1  with start: generate RESTART instead of START
- write  in  1  request: transmit din
- read  in  1  request: receive a byte
- stop  in  1  request: generate STOP after the ACK phase (or alone)
- ack_in  in  1  ACK bit to drive after a read (0 = ACK, 1 = NACK)
- din  in  8  byte to transmit, MSB first
- cmd_ack  out  1  one-cycle pulse: request complete or aborted
- ack_out  out  1  ACK bit sampled from slave after a write
- dout  out  8  received byte
- i2c_busy  out  1  bus owned by this master (START done, STOP not yet done)
- i2c_al  out  1  arbitration lost on the last request
- bit_cmd  out  3  command to bit controller
- bit_din  out  1  data bit to bit controller
- bit_ack  in  1  bit controller command-complete pulse
- bit_arblost  in  1  bit controller arbitration lost
- bit_dout  in  1  sampled SDA from bit controller

## Operation
- Reset / enable=0: state IDLE, bit_cmd=CMD_IDLE, bit_din=1, cmd_ack=0, ack_out=0, dout=0, i2c_busy=0, i2c_al=0, bit counter=0, shift reg=0.
- States: IDLE, START, WRITE, READ, ACK, STOP.
- IDLE: when cmd_ack=0 and any of start/write/read/stop is high, latch all request bits, din and ack_in; clear i2c_al. Next state is the first applicable of START, WRITE, READ or STOP. Requests are ignored in the cycle cmd_ack is high. Requests present only while IDLE are acted on.
- START: bit_cmd=CMD_RESTART if restart else CMD_START. On bit_ack set i2c_busy=1, go to WRITE/READ/STOP/done.
- WRITE: bit_cmd=CMD_WRITE, bit_din=shift[7]. On each bit_ack shift left, count++; after 8th go to ACK.
- READ: bit_cmd=CMD_READ. On each bit_ack shift in bit_dout at LSB, count++; after 8th go to ACK.
- ACK after write: bit_cmd=CMD_READ, on bit_ack ack_out<=bit_dout. ACK after read: bit_cmd=CMD_WRITE, bit_din=latched ack_in; on bit_ack dout<=shift reg.
- Then STOP if stop latched, else done.
- STOP: bit_cmd=CMD_STOP, bit_din=1. On bit_ack clear i2c_busy, done.
- Done: state IDLE, bit_cmd=CMD_IDLE, cmd_ack=1 for one cycle.
- write and read both set: write wins. Counter is 3 bits and wraps 7->0 on the 8th bit.
- bit_arblost in any non-IDLE state: abort. Go to IDLE, bit_cmd=CMD_IDLE, bit_din=1, i2c_busy=0, i2c_al=1, cmd_ack pulse, drop latched requests. This takes priority over a simultaneous bit_ack.

## Timing
- All outputs registered.
- Request accepted in IDLE -> bit_cmd valid next cycle.
- bit_cmd and bit_din are held constant until bit_ack. They change in the cycle after bit_ack to the next command or CMD_IDLE, so the bit controller never re-samples a stale command.
- cmd_ack asserts the cycle after the final bit_ack (or bit_arblost). dout and ack_out are valid in that cycle and held until overwritten.
- bit_ack is a single-cycle pulse. Each pulse advances exactly one bit.
- Reset or enable low mid-transfer: all state returns to reset values on the next edge, and no cmd_ack is generated.

## Test plan
- start+write, din=0xA5; bit model acks each command after 20 cycles, slave ACK=0 -> bit_cmd sequence START, 8×WRITE with bit_din 1,0,1,0,0,1,0,1, READ; ack_out=0, i2c_busy=1, single cmd_ack pulse.
- read+stop+ack_in=1, bit_dout pattern 0x3C -> 8×READ, WRITE with bit_din=1, STOP; dout=0x3C, i2c_busy=0 after cmd_ack.
- start+restart+write while i2c_busy=1 -> first bit_cmd=CMD_RESTART (5); byte completes normally.
- bit_arblost on 4th write bit, coincident with bit_ack -> next cycle bit_cmd=0, i2c_al=1, i2c_busy=0, cmd_ack=1; no further commands.
- Requests held high through cmd_ack -> no second transfer starts in the cmd_ack cycle. Dropping them the following cycle leaves bit_cmd=0.
- nReset low during 5th read bit -> next cycle bit_cmd=0, bit_din=1, all status outputs 0, no cmd_ack.
